// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings
// and the word-alignment mask.
package pc_pkg;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

  // Clears the two byte-offset bits of an address; sliced to WIDTH (WIDTH <= 64).
  localparam logic [63:0] ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/pc_unit_if.sv
// Control/fetch-side bundle of the PC unit. The control unit drives the master
// side; pc_unit implements the slave side.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             PCWre;
  logic [1:0]       sel;
  logic             call;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;
  logic             misaligned;

  modport master (
    output PCWre, sel, call, branch_offset, jump_target,
    input  pc, pc_plus, ras_empty, ras_full, ras_underflow, misaligned
  );

  modport slave (
    input  PCWre, sel, call, branch_offset, jump_target,
    output pc, pc_plus, ras_empty, ras_full, ras_underflow, misaligned
  );

endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack. Never stalls: a push when full overwrites the
// oldest entry. A pop on empty leaves the stack alone and sets a sticky flag.
// push and pop together replace the top entry in place.
module return_addr_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             underflow_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] entries_q [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             uf_q, uf_d;
  logic             wr_en;
  logic [PtrW-1:0]  wr_idx;

  // Pointer/count/flag next state and the entry write port.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    uf_d   = uf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      if (cnt_q == '0) begin
        // Return on empty, then the push lands as the single live entry.
        uf_d   = 1'b1;
        ptr_d  = ptr_q + PtrW'(1);
        cnt_d  = CntW'(1);
        wr_en  = 1'b1;
        wr_idx = ptr_q + PtrW'(1);
      end else begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
      end
    end else if (push_i) begin
      ptr_d  = ptr_q + PtrW'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PtrW'(1);
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop_i) begin
      if (cnt_q == '0) begin
        uf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CntMax);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      uf_q    <= uf_d;
    end
  end

  // Entry storage; contents are don't-care after reset, but a reset still blocks a write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      entries_q[wr_idx] <= push_data_i;
    end
  end

  assign top_o       = entries_q[ptr_q];
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign underflow_o = uf_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection (sequential, relative
// branch, absolute jump, return) and the sticky misalignment flag. Return
// addresses live in the return_addr_stack sub-module.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4,
  parameter int unsigned      INC          = 4
) (
  input logic      CLK,
  input logic      RST,
  pc_unit_if.slave ctrl_if
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_uf;
  logic             push;
  logic             pop;
  logic             mis_q, mis_d;
  pc_sel_e          sel;

  // Stack operations only happen on a PC write.
  assign sel  = pc_sel_e'(ctrl_if.sel);
  assign push = ctrl_if.PCWre & ctrl_if.call;
  assign pop  = ctrl_if.PCWre & (sel == PC_RET);

  // Next-PC mux; the stack top is read before any same-edge write.
  always_comb begin
    pc_plus    = pc_q + WIDTH'(INC);
    branch_tgt = pc_plus + (ctrl_if.branch_offset << 2);
    raw_next   = pc_plus;
    unique case (sel)
      PC_SEQ:    raw_next = pc_plus;
      PC_BRANCH: raw_next = branch_tgt;
      PC_JUMP:   raw_next = ctrl_if.jump_target;
      PC_RET:    raw_next = ras_empty ? pc_plus : ras_top;
    endcase
    pc_d  = pc_q;
    mis_d = mis_q;
    if (ctrl_if.PCWre) begin
      pc_d = raw_next & ALIGN_MASK[WIDTH-1:0];
      if (raw_next[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end
  end

  // PC register and sticky misalignment flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  return_addr_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_plus),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full),
    .underflow_o (ras_uf)
  );

  assign ctrl_if.pc            = pc_q;
  assign ctrl_if.pc_plus       = pc_plus;
  assign ctrl_if.ras_empty     = ras_empty;
  assign ctrl_if.ras_full      = ras_full;
  assign ctrl_if.ras_underflow = ras_uf;
  assign ctrl_if.misaligned    = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic. The driver
// updates a queue-based reference model and posts the expected outputs after
// each edge; an independent monitor pops and compares on the falling edge.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(W)) bus ();

  pc_unit #(
    .WIDTH        (W),
    .RESET_VECTOR (32'h0000_0000),
    .RAS_DEPTH    (D),
    .INC          (4)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .ctrl_if (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        empty;
    logic        full;
    logic        uf;
    logic        mis;
  } snap_t;

  snap_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model: return stack as a queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_uf;
  logic        m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic we, input logic [1:0] s, input logic c,
                       input logic [31:0] off, input logic [31:0] tgt);
    logic [31:0] pp;
    logic [31:0] raw;
    if (r) begin
      m_pc  = 32'h0;
      m_ras.delete();
      m_uf  = 1'b0;
      m_mis = 1'b0;
    end else if (we) begin
      pp  = m_pc + 32'd4;
      raw = pp;
      case (s)
        2'b00: raw = pp;
        2'b01: raw = pp + (off << 2);
        2'b10: raw = tgt;
        default: begin
          if (m_ras.size() > 0) raw = m_ras[$];
          else begin
            raw  = pp;
            m_uf = 1'b1;
          end
        end
      endcase
      if (c && s == 2'b11) begin
        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = pp;
        else m_ras.push_back(pp);
      end else if (c) begin
        m_ras.push_back(pp);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end else if (s == 2'b11 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
      if (raw[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = {raw[31:2], 2'b00};
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [1:0] s, input logic c,
                      input logic [31:0] off, input logic [31:0] tgt);
    snap_t e;
    rst               = r;
    bus.PCWre         = we;
    bus.sel           = s;
    bus.call          = c;
    bus.branch_offset = off;
    bus.jump_target   = tgt;
    model(r, we, s, c, off, tgt);
    @(posedge clk);
    #1;
    e.pc      = m_pc;
    e.pc_plus = m_pc + 32'd4;
    e.empty   = (m_ras.size() == 0);
    e.full    = (m_ras.size() == D);
    e.uf      = m_uf;
    e.mis     = m_mis;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every posted expectation against the DUT outputs.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("pc_plus", bus.pc_plus, e.pc_plus);
        chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
        chk("ras_full", 32'(bus.ras_full), 32'(e.full));
        chk("ras_underflow", 32'(bus.ras_underflow), 32'(e.uf));
        chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
      end
    end
  end

  initial begin
    logic [1:0]  s;
    logic [31:0] off;
    logic [31:0] tgt;
    rst               = 1'b1;
    bus.PCWre         = 1'b0;
    bus.sel           = PC_SEQ;
    bus.call          = 1'b0;
    bus.branch_offset = '0;
    bus.jump_target   = '0;

    // Reset, then three sequential steps.
    step(1, 0, PC_SEQ, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, PC_SEQ, 0, 0, 0);
    // Hold: nothing moves even with jump+call presented.
    step(0, 0, PC_JUMP, 1, 0, 32'h100);
    // Branch wrap and negative offset.
    step(0, 1, PC_JUMP, 0, 0, 32'hFFFF_FFF8);
    step(0, 1, PC_BRANCH, 0, 32'd2, 0);
    step(0, 1, PC_JUMP, 0, 0, 32'h20);
    step(0, 1, PC_BRANCH, 0, 32'hFFFF_FFFD, 0);
    // Nested call/return.
    step(1, 0, PC_SEQ, 0, 0, 0);
    step(0, 1, PC_JUMP, 0, 0, 32'h10);
    step(0, 1, PC_JUMP, 1, 0, 32'h100);
    step(0, 1, PC_SEQ, 0, 0, 0);
    step(0, 1, PC_JUMP, 1, 0, 32'h200);
    step(0, 1, PC_RET, 0, 0, 0);
    step(0, 1, PC_RET, 0, 0, 0);
    // Overflow with five calls, then five returns ending in underflow.
    for (int i = 0; i < 5; i++) step(0, 1, PC_JUMP, 1, 0, 32'h1000 + 32'(i * 16));
    for (int i = 0; i < 5; i++) step(0, 1, PC_RET, 0, 0, 0);
    step(0, 1, PC_SEQ, 0, 0, 0);
    // Call+return together, then a misaligned jump, then reset.
    step(1, 0, PC_SEQ, 0, 0, 0);
    step(0, 1, PC_JUMP, 0, 0, 32'h2FC);
    step(0, 1, PC_SEQ, 1, 0, 0);
    step(0, 1, PC_JUMP, 0, 0, 32'h40);
    step(0, 1, PC_RET, 1, 0, 0);
    step(0, 1, PC_RET, 0, 0, 0);
    step(0, 1, PC_JUMP, 0, 0, 32'h102);
    step(0, 1, PC_RET, 1, 0, 0);
    step(1, 1, PC_JUMP, 1, 0, 32'h500);
    step(0, 1, PC_SEQ, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s   = 2'($urandom_range(0, 3));
      off = 32'($urandom_range(0, 63)) - 32'd32;
      tgt = 32'($urandom_range(0, 4095)) & ~32'h3;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), s,
           1'($urandom_range(0, 1)), off, tgt);
    end

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle CPU. It holds the current instruction address and computes the next one: sequential, PC-relative branch, absolute jump, or return-from-call. It contains a circular return-address stack (RAS) that is pushed on calls and popped on returns. It sits between the control unit (PCWre, next-PC select) and instruction memory (address).

## Interface

**Parameters**
- `WIDTH`, default 32: address width in bits; must be ≥ 8.
- `RESET_VECTOR`, default 32'h00000000: PC value after reset; bits [1:0] must be 0.
- `RAS_DEPTH`, default 4: number of return-stack entries; must be a power of 2, ≥ 2.
- `INC`, default 4: sequential increment in bytes.

**Ports**
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `PCWre` in 1: PC write enable. When low, PC, RAS and flags hold.
- `sel` in 2: next-PC source.
  - 00 SEQ
  - 01 BRANCH
  - 10 JUMP
  - 11 RET
- `call` in 1: push the return address PC+INC when `PCWre` is high.
- `branch_offset` in WIDTH: signed word offset.
- `jump_target` in WIDTH: absolute byte address.
- `pc` out WIDTH: current PC (registered).
- `pc_plus` out WIDTH: combinational `pc + INC`.
- `ras_empty` out 1: registered; count == 0.
- `ras_full` out 1: registered; count == RAS_DEPTH.
- `ras_underflow` out 1: sticky; set by a RET on an empty stack.
- `misaligned` out 1: sticky; set when a computed next PC has bits [1:0] ≠ 0.

## Operation

**Next-PC computation** (all sums modulo 2^WIDTH, carry discarded):
- SEQ: `pc + INC`.
- BRANCH: `pc + INC + (branch_offset << 2)`.
- JUMP: `jump_target`.
- RET:
  - If the RAS is non-empty: the top entry.
  - If the RAS is empty: `pc + INC`, and `ras_underflow` is set.

**Alignment**
- The loaded PC always has bits [1:0] forced to 0.
- If the raw next value had nonzero low bits, `misaligned` is set.

**Reset**
- Reset has priority over everything else.
- `pc` = RESET_VECTOR; RAS count = 0 and pointer = 0; `ras_empty` = 1.
- `ras_full`, `ras_underflow` and `misaligned` = 0.
- RAS entry contents are don't-care after reset.

**PCWre = 0**: all state holds. `call` and `sel` are ignored, so no push and no pop occur.

**RAS behaviour when PCWre = 1**
- Push only (`call`=1, sel≠RET):
  - Write `pc + INC` at ptr+1; ptr advances.
  - count = min(count+1, RAS_DEPTH).
  - When full, the oldest entry is overwritten; the stack is circular and never stalls.
- Pop only (`call`=0, sel=RET, count>0): ptr decrements; count−1.
- Pop on empty: no pointer or count change; `ras_underflow` is set.
- Call and return together (`call`=1, sel=RET):
  - Next PC = current top.
  - The top entry is replaced with `pc + INC`.
  - Count is unchanged.
  - If empty, behave as RET-on-empty followed by a push, giving count = 1.
- `call` combined with BRANCH or JUMP is a normal call: push, and PC takes the selected target.

**Sticky flags**: `ras_underflow` and `misaligned` clear only on RST.

## Timing
- Latency: the PC loaded at edge N is the value computed from inputs sampled at edge N. `pc` is visible after edge N.
- `pc_plus` follows `pc` combinationally, with no extra cycle.
- `ras_empty` and `ras_full` update on the same edge as the push or pop.
- The RET target reads the top entry before any same-edge write.
- Flags are set on the edge that performs the faulting update.
- RST asserted mid-sequence (for example on the edge of a call) wins: no push occurs.
- The `initial`-free design relies on RST. Outputs are X until the first reset edge.

## Structure
- Shared package `pc_pkg` holds:
  - `sel` encodings PC_SEQ, PC_BRANCH, PC_JUMP, PC_RET.
  - The alignment mask constant.
- Sub-module `return_addr_stack` (parameters WIDTH, RAS_DEPTH):
  - Ports: push, pop, push_data, top, empty, full, underflow.
  - Internals: circular pointer, count.
  - The top level keeps the PC register, next-PC mux/adders and `misaligned`.
- Expected size: about 150–250 lines total.

## Test plan
- **Reset and sequential:** RST=1 for one edge, then PCWre=1, sel=SEQ for 3 edges → pc = 0, 4, 8, 0xC. `ras_empty`=1.
- **Hold:** PCWre=0 with sel=JUMP, jump_target=0x100, call=1 → pc unchanged, RAS count unchanged.
- **Branch wrap:** pc=0xFFFFFFF8, sel=BRANCH, branch_offset=2 → pc=0x00000004 (wrap). branch_offset=−3 from pc=0x20 → pc=0x18.
- **Call/return nesting:** JUMP with call from 0x10→0x100, then 0x104 JUMP+call→0x200, then RET→0x108, then RET→0x14. `ras_empty`=1 at the end, `ras_underflow`=0.
- **Overflow and underflow:** with RAS_DEPTH=4, do 5 calls → `ras_full`=1 and the first return address is lost. 4 RETs return in LIFO order. A 5th RET → pc = pc+4 and `ras_underflow`=1, staying set until RST.
- **Simultaneous and misaligned:** call+RET with top=0x300 at pc=0x40 → pc=0x300, top becomes 0x44, count unchanged. JUMP to 0x102 → pc=0x100 and `misaligned`=1. RST on the next edge clears both flags.
